// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, state encoding and tag-width helper for the instruction cache
package icache_pkg;
  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_DATA_BUS = 32;
  localparam int ICACHE_INDEX_BITS = 6;
  typedef enum logic {
    ICACHE_IDLE  = 1'b0,
    ICACHE_FETCH = 1'b1
  } state_e;
  function automatic int tag_bits(input int addr_width, input int index_bits);
    return addr_width - index_bits - 2;
  endfunction
endpackage

// File: rtl/icache_ram.sv
// icache_ram: valid/tag/data arrays; async read by index, sync write, sync valid clear on reset
//  clock, reset            : clock and synchronous active-high reset (clears every valid bit)
//  rd_index -> rd_valid/rd_tag/rd_data : combinational lookup port
//  we, wr_index, wr_tag, wr_data       : synchronous fill port, sets valid[wr_index]
module icache_ram
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = tag_bits(MEM_ADDR_BUS, ICACHE_INDEX_BITS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [INDEX_BITS-1:0]   rd_index,
  output logic                    rd_valid,
  output logic [TAG_BITS-1:0]     rd_tag,
  output logic [MEM_DATA_BUS-1:0] rd_data,
  input  logic                    we,
  input  logic [INDEX_BITS-1:0]   wr_index,
  input  logic [TAG_BITS-1:0]     wr_tag,
  input  logic [MEM_DATA_BUS-1:0] wr_data
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_BITS-1:0]     tag_q  [LINES];
  logic [MEM_DATA_BUS-1:0] data_q [LINES];
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_index] = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end
  // Tag/data need no reset: an entry is only trusted through its valid bit.
  always_ff @(posedge clock) begin
    if (we && !reset) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end
  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache between IF and the memory controller
//  clock, reset                  : single clock, synchronous active-high reset
//  if_req, if_pc, if_flush       : fetch request (held until if_ready/if_flush), redirect cancel
//  if_ready, if_inst             : one-cycle delivery pulse and instruction word
//  mc_read, mc_addr              : registered fetch request to controller, held until mc_ready
//  mc_busy, mc_ready, mc_data    : controller status (unused), completion pulse and word
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_WIDTH = MEM_ADDR_BUS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_pc,
  input  logic                    if_flush,
  output logic                    if_ready,
  output logic [MEM_DATA_BUS-1:0] if_inst,
  output logic                    mc_read,
  output logic [ADDR_WIDTH-1:0]   mc_addr,
  input  logic                    mc_busy,
  input  logic                    mc_ready,
  input  logic [MEM_DATA_BUS-1:0] mc_data
);
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  state_e                  state_q, state_d;
  logic                    drop_q, drop_d;
  logic                    if_ready_q, if_ready_d;
  logic [MEM_DATA_BUS-1:0] if_inst_q, if_inst_d;
  logic                    mc_read_q, mc_read_d;
  logic [ADDR_WIDTH-1:0]   mc_addr_q, mc_addr_d;
  logic                    rd_valid;
  logic [TAG_BITS-1:0]     rd_tag;
  logic [MEM_DATA_BUS-1:0] rd_data;
  logic                    lookup, hit, miss, fill, deliver;
  logic                    unused_ok;
  assign unused_ok = &{1'b0, mc_busy, if_pc[1:0]};
  icache_ram #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_ram (
    .clock    (clock),
    .reset    (reset),
    .rd_index (if_pc[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill),
    .wr_index (mc_addr_q[INDEX_BITS+1:2]),
    .wr_tag   (mc_addr_q[ADDR_WIDTH-1:INDEX_BITS+2]),
    .wr_data  (mc_data)
  );
  // No lookup while a delivery pulse is out, so a held if_req is not served twice.
  assign lookup  = (state_q == ICACHE_IDLE) && if_req && !if_flush && !if_ready_q;
  assign hit     = lookup && rd_valid && (rd_tag == if_pc[ADDR_WIDTH-1:INDEX_BITS+2]);
  assign miss    = lookup && !hit;
  assign fill    = (state_q == ICACHE_FETCH) && mc_ready;
  assign deliver = fill && !drop_q && !if_flush;
  always_comb begin
    state_d    = miss ? ICACHE_FETCH : fill ? ICACHE_IDLE : state_q;
    mc_read_d  = miss || (mc_read_q && !fill);
    mc_addr_d  = miss ? {if_pc[ADDR_WIDTH-1:2], 2'b00} : mc_addr_q;
    if_ready_d = hit || deliver;
    if_inst_d  = hit ? rd_data : deliver ? mc_data : if_inst_q;
    // A redirect during a fill lets the fill land in the array but suppresses its delivery.
    drop_d     = (state_q == ICACHE_FETCH) && !fill && (drop_q || if_flush);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ICACHE_IDLE;
      drop_q     <= 1'b0;
      if_ready_q <= 1'b0;
      if_inst_q  <= '0;
      mc_read_q  <= 1'b0;
      mc_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      if_ready_q <= if_ready_d;
      if_inst_q  <= if_inst_d;
      mc_read_q  <= mc_read_d;
      mc_addr_q  <= mc_addr_d;
    end
  end
  assign if_ready = if_ready_q;
  assign if_inst  = if_inst_q;
  assign mc_read  = mc_read_q;
  assign mc_addr  = mc_addr_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scoreboard bench for icache
module tb_icache;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_flush = 1'b0;
  logic        if_ready;
  logic [31:0] if_inst;
  logic        mc_read;
  logic [31:0] mc_addr;
  logic        mc_busy = 1'b0;
  logic        mc_ready = 1'b0;
  logic [31:0] mc_data = '0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic        prev_ready = 1'b0;

  icache dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_pc    (if_pc),
    .if_flush (if_flush),
    .if_ready (if_ready),
    .if_inst  (if_inst),
    .mc_read  (mc_read),
    .mc_addr  (mc_addr),
    .mc_busy  (mc_busy),
    .mc_ready (mc_ready),
    .mc_data  (mc_data)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin : monitor
    logic [31:0] e;
    if (!reset && if_ready) begin
      checks++;
      if (prev_ready) begin
        errors++;
        $display("FAIL if_ready_pulse: if_ready high two cycles in a row, required single pulse");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: if_ready=1 inst=%08h, required no delivery", if_inst);
      end else begin
        e = exp_q.pop_front();
        if (if_inst !== e) begin
          errors++;
          $display("FAIL sb_inst: got %08h, required %08h", if_inst, e);
        end
      end
    end
    prev_ready = if_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input bit hit_exp, input logic [31:0] data);
    exp_q.push_back(data);
    if_req = 1'b1;
    if_pc  = pc;
    step();
    if (hit_exp) begin
      chk("hit_ready", {31'b0, if_ready}, 32'd1);
      chk("hit_no_mc_read", {31'b0, mc_read}, 32'd0);
    end else begin
      chk("miss_no_ready", {31'b0, if_ready}, 32'd0);
      chk("miss_mc_read", {31'b0, mc_read}, 32'd1);
      chk("miss_mc_addr", mc_addr, {pc[31:2], 2'b00});
      mc_busy = 1'b1;
      step();
      chk("fetch_hold_read", {31'b0, mc_read}, 32'd1);
      mc_ready = 1'b1;
      mc_data  = data;
      step();
      mc_ready = 1'b0;
      mc_busy  = 1'b0;
      chk("fill_ready", {31'b0, if_ready}, 32'd1);
      chk("fill_mc_read_drop", {31'b0, mc_read}, 32'd0);
    end
    if_req = 1'b0;
    step();
    chk("ready_pulse_end", {31'b0, if_ready}, 32'd0);
    chk("inst_hold", if_inst, data);
    chk("no_reraise", {31'b0, mc_read}, 32'd0);
  endtask

  task automatic start_miss(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    step();
    chk("miss_mc_read", {31'b0, mc_read}, 32'd1);
    chk("miss_mc_addr", mc_addr, pc);
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mc_read", {31'b0, mc_read}, 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    // cold miss, hit, conflict
    fetch(32'h0000_0010, 1'b0, 32'h0010_0093);
    fetch(32'h0000_0010, 1'b1, 32'h0010_0093);
    fetch(32'h0000_0110, 1'b0, 32'h1100_0113);
    fetch(32'h0000_0010, 1'b0, 32'h0010_0093);
    fetch(32'h0000_0013, 1'b1, 32'h0010_0093);
    // flush during fill: fill is written but not delivered
    start_miss(32'h0000_0020);
    if_req   = 1'b0;
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    chk("flush_mid_read", {31'b0, mc_read}, 32'd1);
    step();
    mc_ready = 1'b1;
    mc_data  = 32'h0200_0513;
    step();
    mc_ready = 1'b0;
    chk("flush_mid_no_ready", {31'b0, if_ready}, 32'd0);
    chk("flush_mid_read_drop", {31'b0, mc_read}, 32'd0);
    step();
    fetch(32'h0000_0020, 1'b1, 32'h0200_0513);
    // flush in the same cycle as mc_ready
    start_miss(32'h0000_0030);
    step();
    if_req   = 1'b0;
    if_flush = 1'b1;
    mc_ready = 1'b1;
    mc_data  = 32'h0300_0593;
    step();
    if_flush = 1'b0;
    mc_ready = 1'b0;
    chk("flush_rdy_no_ready", {31'b0, if_ready}, 32'd0);
    chk("flush_rdy_read_drop", {31'b0, mc_read}, 32'd0);
    step();
    fetch(32'h0000_0030, 1'b1, 32'h0300_0593);
    // flush together with a would-be hit wins
    if_req   = 1'b1;
    if_pc    = 32'h0000_0010;
    if_flush = 1'b1;
    step();
    if_req   = 1'b0;
    if_flush = 1'b0;
    chk("flush_idle_no_ready", {31'b0, if_ready}, 32'd0);
    chk("flush_idle_no_read", {31'b0, mc_read}, 32'd0);
    step();
    // reset mid-fill with mc_ready in the same cycle
    start_miss(32'h0000_0040);
    if_req   = 1'b0;
    reset    = 1'b1;
    mc_ready = 1'b1;
    mc_data  = 32'hdead_beef;
    step();
    reset    = 1'b0;
    mc_ready = 1'b0;
    chk("rst_fill_read", {31'b0, mc_read}, 32'd0);
    chk("rst_fill_ready", {31'b0, if_ready}, 32'd0);
    step();
    fetch(32'h0000_0010, 1'b0, 32'h0010_0093);
    fetch(32'h0000_0040, 1'b0, 32'h0400_0613);
    step();
    step();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
